// File: rtl/hsi_encoder_if.sv
// Byte-input handshake for the HSI encoder: the producer drives a byte with its
// end-of-message flag, the encoder answers with din_rdy while its FIFO has room.
interface hsi_encoder_if;
  logic [7:0] din;
  logic       din_vld;
  logic       din_last;
  logic       din_rdy;

  modport master (
    output din,
    output din_vld,
    output din_last,
    input  din_rdy
  );

  modport slave (
    input  din,
    input  din_vld,
    input  din_last,
    output din_rdy
  );
endinterface

// File: rtl/hsi_encoder.sv
// HSI serial encoder: buffers bytes in a 4-deep FIFO and sends each as an
// 11-slot frame (start, 8 data, odd parity, stop), 8 line ticks per slot.
// Frames of one message go out back-to-back; every message (or an underrun)
// is followed by a 16-tick idle-high gap before the next message may start.
module hsi_encoder #(
  parameter string ML_FST = "LSB"   // "LSB": d0 first, "MSB": d7 first
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clk_en,
  hsi_encoder_if.slave byte_if,
  output logic         q,
  output logic         busy,
  output logic         tx_done,
  output logic         underrun
);

  localparam bit MSB_FIRST = (ML_FST == "MSB");

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input FIFO: 4 words of {last, data}; runs on every clk, not gated by clk_en
  // ---------------------------------------------------------------------------
  logic [8:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic [8:0] head;

  assign fifo_full       = (count == 3'd4);
  assign fifo_empty      = (count == 3'd0);
  assign byte_if.din_rdy = ~fifo_full;
  assign push            = byte_if.din_vld & ~fifo_full;
  assign head            = mem[rd_ptr];

  // Store accepted bytes.
  // NOTE: the storage array is deliberately not reset; an entry is only read
  // after it has been written, and only the pointers/count define emptiness.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {byte_if.din_last, byte_if.din};
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count alone.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  state_t     state,    state_n;
  logic [2:0] tick_cnt, tick_n;   // tick within the current bit slot
  logic [2:0] bit_idx,  idx_n;    // data bit being sent
  logic [3:0] gap_cnt,  gap_n;    // ticks spent in the post-message gap
  logic [7:0] data_r,   data_n;
  logic       last_r,   last_n;
  logic       q_r,      q_n;
  logic       done_n;
  logic       unr_n;
  logic       slot_end;

  assign slot_end = (tick_cnt == 3'd7);
  assign q        = q_r;
  assign busy     = (state != IDLE);

  // Pick data bit i in line order.
  function automatic logic sel_bit(input logic [7:0] d, input logic [2:0] i);
    return MSB_FIRST ? d[3'd7 - i] : d[i];
  endfunction

  // Next-state and next-output logic; everything holds unless clk_en ticks.
  always_comb begin
    // NOTE: every signal written here gets its default first, so no branch can
    // leave one unassigned and infer a latch.
    state_n = state;
    tick_n  = tick_cnt;
    idx_n   = bit_idx;
    gap_n   = gap_cnt;
    data_n  = data_r;
    last_n  = last_r;
    q_n     = q_r;
    pop     = 1'b0;
    done_n  = 1'b0;
    unr_n   = 1'b0;

    if (clk_en) begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_n  = head[7:0];
            last_n  = head[8];
            tick_n  = 3'd0;
            q_n     = 1'b0;
            state_n = START;
          end
        end
        START: begin
          tick_n = tick_cnt + 3'd1;
          if (slot_end) begin
            idx_n   = 3'd0;
            q_n     = sel_bit(data_r, 3'd0);
            state_n = DATA;
          end
        end
        DATA: begin
          tick_n = tick_cnt + 3'd1;
          if (slot_end) begin
            if (bit_idx == 3'd7) begin
              q_n     = ~^data_r;
              state_n = PARITY;
            end else begin
              idx_n = bit_idx + 3'd1;
              q_n   = sel_bit(data_r, bit_idx + 3'd1);
            end
          end
        end
        PARITY: begin
          tick_n = tick_cnt + 3'd1;
          if (slot_end) begin
            q_n     = 1'b1;
            state_n = STOP;
          end
        end
        STOP: begin
          tick_n = tick_cnt + 3'd1;
          if (slot_end) begin
            if (!last_r && !fifo_empty) begin
              // Next byte of the same message: start bit follows stop at once.
              pop     = 1'b1;
              data_n  = head[7:0];
              last_n  = head[8];
              q_n     = 1'b0;
              state_n = START;
            end else begin
              gap_n   = 4'd0;
              q_n     = 1'b1;
              unr_n   = ~last_r;
              state_n = GAP;
            end
          end
        end
        GAP: begin
          gap_n = gap_cnt + 4'd1;
          if (gap_cnt == 4'd15) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
        default: begin
          q_n     = 1'b1;
          state_n = IDLE;
        end
      endcase
    end
  end

  // State, counters, line register and event pulses.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      tick_cnt <= 3'd0;
      bit_idx  <= 3'd0;
      gap_cnt  <= 4'd0;
      data_r   <= 8'd0;
      last_r   <= 1'b0;
      q_r      <= 1'b1;
      tx_done  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_idx  <= idx_n;
      gap_cnt  <= gap_n;
      data_r   <= data_n;
      last_r   <= last_n;
      q_r      <= q_n;
      tx_done  <= done_n;
      underrun <= unr_n;
    end
  end

endmodule

// File: tb/tb_hsi_encoder.sv
// Self-checking bench for hsi_encoder (LSB-first build). A frame-level model
// (byte queue + frame bit vector + tick position) predicts the line and the
// status outputs every clk; directed tests add hand-computed literal checks.
module tb_hsi_encoder;

  logic clk = 1'b0;
  logic n_rst;
  logic clk_en;
  logic q, busy, tx_done, underrun;

  hsi_encoder_if byte_if ();

  hsi_encoder #(.ML_FST("LSB")) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .clk_en   (clk_en),
    .byte_if  (byte_if),
    .q        (q),
    .busy     (busy),
    .tx_done  (tx_done),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Line-rate tick generator: one tick every en_div clks, or none when en_off
  // ---------------------------------------------------------------------------
  int en_div = 1;
  int en_cnt = 0;
  bit en_off = 1'b1;

  always @(negedge clk) begin
    if (en_off) begin
      clk_en = 1'b0;
      en_cnt = 0;
    end else begin
      clk_en = (en_cnt == 0);
      en_cnt = (en_cnt + 1 >= en_div) ? 0 : en_cnt + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame-level reference model
  // ---------------------------------------------------------------------------
  logic [8:0]  mq [$];
  int          m_phase = 0;    // 0 idle, 1 sending a frame, 2 gap
  int          m_tick  = 0;    // ticks elapsed since the frame's start edge
  int          m_gap   = 0;
  logic [10:0] m_bits  = '1;   // slot k of the current frame is m_bits[k]
  logic        m_last  = 1'b0;
  logic        e_q     = 1'b1;
  logic        e_busy  = 1'b0;
  logic        e_txd   = 1'b0;
  logic        e_unr   = 1'b0;

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic load_frame();
    logic [8:0] h;
    h       = mq.pop_front();
    m_bits  = frame_of(h[7:0]);
    m_last  = h[8];
    m_phase = 1;
    m_tick  = 0;
  endtask

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mq.delete();
      m_phase = 0;
      m_tick  = 0;
      m_gap   = 0;
      e_q     = 1'b1;
      e_busy  = 1'b0;
      e_txd   = 1'b0;
      e_unr   = 1'b0;
    end else begin
      logic       acc;
      logic [8:0] w;
      acc   = byte_if.din_vld && (mq.size() < 4);
      w     = {byte_if.din_last, byte_if.din};
      e_txd = 1'b0;
      e_unr = 1'b0;
      if (clk_en) begin
        case (m_phase)
          0: if (mq.size() > 0) load_frame();
          1: begin
            m_tick++;
            if (m_tick == 88) begin
              if (!m_last && mq.size() > 0) begin
                load_frame();
              end else begin
                m_phase = 2;
                m_gap   = 0;
                e_unr   = !m_last;
              end
            end
          end
          default: begin
            m_gap++;
            if (m_gap == 16) begin
              m_phase = 0;
              e_txd   = 1'b1;
            end
          end
        endcase
      end
      if (acc) mq.push_back(w);
      e_q    = (m_phase == 1) ? m_bits[m_tick / 8] : 1'b1;
      e_busy = (m_phase != 0);
    end
  end

  // Per-cycle comparison against the model.
  bit cmp_on = 1'b0;

  always @(negedge clk) begin
    if (cmp_on) begin
      check("q",        q,               e_q);
      check("busy",     busy,            e_busy);
      check("tx_done",  tx_done,         e_txd);
      check("underrun", underrun,        e_unr);
      check("din_rdy",  byte_if.din_rdy, mq.size() < 4);
    end
  end

  // Event counters for message-level checks.
  int txd_cnt = 0;
  int unr_cnt = 0;
  int txd_cyc = 0;
  int unr_cyc = 0;

  always @(negedge clk) begin
    if (tx_done === 1'b1) begin
      txd_cnt <= txd_cnt + 1;
      txd_cyc <= cyc;
    end
    if (underrun === 1'b1) begin
      unr_cnt <= unr_cnt + 1;
      unr_cyc <= cyc;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a negedge)
  // ---------------------------------------------------------------------------
  task automatic push(input logic [7:0] d, input logic l);
    byte_if.din      = d;
    byte_if.din_last = l;
    byte_if.din_vld  = 1'b1;
    @(negedge clk);
    byte_if.din_vld  = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int limit, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (busy === val) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_wait_busy"}, seen, 1'b1);
  endtask

  // Waits for the start bit, then checks every slot at its middle and last clk.
  task automatic sample_slots(input logic [21:0] exp, input int nslots,
                              input int div, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (q === 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_start_seen"}, seen, 1'b1);
    if (seen) begin
      for (int k = 0; k < nslots; k++) begin
        repeat (4 * div) @(negedge clk);
        check($sformatf("%s_mid%0d", tag, k), q, exp[k]);
        repeat (4 * div - 1) @(negedge clk);
        check($sformatf("%s_end%0d", tag, k), q, exp[k]);
        @(negedge clk);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  int txd0;
  int unr0;

  initial begin
    n_rst            = 1'b0;
    byte_if.din      = 8'h00;
    byte_if.din_vld  = 1'b0;
    byte_if.din_last = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_q",        q,               1'b1);
    check("rst_busy",     busy,            1'b0);
    check("rst_txd",      tx_done,         1'b0);
    check("rst_underrun", underrun,        1'b0);
    check("rst_din_rdy",  byte_if.din_rdy, 1'b1);
    #2 n_rst = 1'b1;
    cmp_on = 1'b1;
    en_div = 1;
    en_off = 1'b0;
    @(negedge clk);

    // 0xA5 single-byte message, tick every clk
    push(8'hA5, 1'b1);
    sample_slots({2'b11, 8'hA5, 1'b0}, 11, 1, "a5");
    repeat (15) @(negedge clk);
    check("a5_txd_early", tx_done, 1'b0);
    @(negedge clk);
    check("a5_txd", tx_done, 1'b1);
    check("a5_idle", busy, 1'b0);
    repeat (3) @(negedge clk);

    // Two-byte message 0x00 (last=0), 0xFF (last=1): back-to-back frames
    en_off = 1'b1;
    repeat (2) @(negedge clk);
    txd0 = txd_cnt;
    unr0 = unr_cnt;
    push(8'h00, 1'b0);
    push(8'hFF, 1'b1);
    en_off = 1'b0;
    sample_slots({2'b11, 8'hFF, 1'b0, 2'b11, 8'h00, 1'b0}, 22, 1, "pair");
    wait_busy(1'b0, 200, "pair");
    repeat (2) @(negedge clk);
    check("pair_txd_count", txd_cnt - txd0, 1);
    check("pair_no_underrun", unr_cnt - unr0, 0);

    // FIFO fill with no ticks: 5th byte dropped, line stays idle
    en_off = 1'b1;
    repeat (2) @(negedge clk);
    txd0 = txd_cnt;
    unr0 = unr_cnt;
    for (int i = 0; i < 5; i++) begin
      push(8'h10 + 8'(i), (i == 3));
      check($sformatf("fill_rdy%0d", i), byte_if.din_rdy, (i < 3) ? 1'b1 : 1'b0);
    end
    check("fill_q_idle", q, 1'b1);
    check("fill_busy", busy, 1'b0);
    en_off = 1'b0;
    wait_busy(1'b1, 20, "fill_go");
    wait_busy(1'b0, 1000, "fill_end");
    repeat (20) @(negedge clk);
    check("fill_txd_count", txd_cnt - txd0, 1);
    check("fill_no_underrun", unr_cnt - unr0, 0);
    check("fill_stays_idle", busy, 1'b0);

    // Underrun: one non-last byte
    txd0 = txd_cnt;
    unr0 = unr_cnt;
    push(8'h3C, 1'b0);
    wait_busy(1'b1, 20, "unr_go");
    wait_busy(1'b0, 300, "unr_end");
    repeat (2) @(negedge clk);
    check("unr_count", unr_cnt - unr0, 1);
    check("unr_txd_count", txd_cnt - txd0, 1);
    check("unr_gap_len", txd_cyc - unr_cyc, 16);

    // Reset during the 4th data slot, then a clean 0x81 frame
    en_off = 1'b1;
    repeat (2) @(negedge clk);
    push(8'h5A, 1'b0);
    push(8'h33, 1'b1);
    en_off = 1'b0;
    for (int i = 0; i < 50 && q !== 1'b0; i++) @(negedge clk);
    check("mid_start_seen", q, 1'b0);
    repeat (36) @(negedge clk);
    txd0 = txd_cnt;
    #2 n_rst = 1'b0;
    #1;
    check("mid_rst_q", q, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rdy", byte_if.din_rdy, 1'b1);
    check("mid_rst_txd", tx_done, 1'b0);
    @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    push(8'h81, 1'b1);
    sample_slots({2'b11, 8'h81, 1'b0}, 11, 1, "r81");
    wait_busy(1'b0, 100, "r81");
    repeat (2) @(negedge clk);
    check("r81_txd_count", txd_cnt - txd0, 1);

    // Tick one clk in three: 24-clk slots, same bits as 0xA5 above
    en_div = 3;
    repeat (3) @(negedge clk);
    push(8'hA5, 1'b1);
    sample_slots({2'b11, 8'hA5, 1'b0}, 11, 3, "div3");
    wait_busy(1'b0, 200, "div3");
    repeat (4) @(negedge clk);

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hsi_encoder.md
HSI_ENCODER -- requirements
Module: hsi_encoder

Interface
REQ-001 Port clk input 1: single system clock; all state updates on rising edge.
REQ-002 Port n_rst input 1: reset, asynchronous and active-low.
REQ-003 Port clk_en input 1: line-rate tick; one tick = 1/8 bit period; gates the serializer only.
REQ-004 Port din input 8: byte to transmit.
REQ-005 Port din_vld input 1: din/din_last valid.
REQ-006 Port din_last input 1: byte is final byte of a message.
REQ-007 Port din_rdy output 1: FIFO can accept a byte; combinational, equals FIFO not full.
REQ-008 Port q output 1: serial line, registered, idle high.
REQ-009 Port busy output 1: high in any state other than IDLE.
REQ-010 Port tx_done output 1: one-clk pulse when the post-message gap completes.
REQ-011 Port underrun output 1: one-clk pulse when the FIFO is empty after a non-last frame's stop bit.

Function
REQ-012 The block SHALL contain a 4-entry FIFO of 9-bit words {din_last, din}, written on any clk edge with din_vld & din_rdy, independent of clk_en.
REQ-013 The FIFO SHALL ignore writes when full; a write and a pop on the same edge SHALL keep the count unchanged.
REQ-014 The frame SHALL be 11 bit slots: start(0), 8 data, parity, stop(1); each slot lasts exactly 8 clk_en ticks, giving 88 ticks per frame.
REQ-015 Data order SHALL follow the ML_FST configuration: LSB gives d0..d7, MSB gives d7..d0; parity is always sent after data.
REQ-016 The parity bit SHALL be ~^data (odd parity over 8 data bits).
REQ-017 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP, GAP; transitions occur only on clk_en ticks.
REQ-018 A 3-bit tick counter SHALL advance on each clk_en tick; a slot ends when the counter is 7 and clk_en is high; the counter wraps to 0.
REQ-019 In DATA, a 3-bit bit index SHALL advance per slot; DATA exits to PARITY after index 7.
REQ-020 IDLE -> START SHALL occur on a clk_en tick with the FIFO non-empty: the head is popped into the shift register and q goes 0 on that edge.
REQ-021 STOP end with a non-last frame and FIFO non-empty SHALL enter START directly, popping the next byte, so frames within a message are back-to-back with no idle bit.
REQ-022 STOP end with a last frame SHALL enter GAP.
REQ-023 STOP end with a non-last frame and FIFO empty SHALL enter GAP and pulse underrun.
REQ-024 GAP SHALL hold q=1 for 16 ticks, then enter IDLE and pulse tx_done on the same edge.
REQ-025 A new message SHALL NOT start before GAP completes, even if the FIFO is non-empty.
REQ-026 With clk_en low, the FSM, counters and q SHALL hold their values.

Reset
REQ-027 While n_rst=0: q=1, busy=0, tx_done=0, underrun=0, FIFO empty (din_rdy=1), state IDLE, all counters 0.
REQ-028 Reset asserted mid-frame SHALL abort immediately, return q high, and discard FIFO contents; no tx_done is issued.

Verification
REQ-029 LSB mode, clk_en every clk, push 0xA5 with last=1 -> q = 0,1,0,1,0,0,1,0,1,1(parity),1(stop), each held 8 clks; tx_done 16 clks after the stop slot ends; busy=0 afterwards.
REQ-030 Push 0x00 (last=0) then 0xFF (last=1) -> second start bit immediately follows the first stop bit; parities are 1 and 1; a single tx_done.
REQ-031 clk_en held low, push 5 bytes -> din_rdy falls after the 4th write; the 5th byte is not stored; q stays 1.
REQ-032 Push 0x3C with last=0 and nothing else -> underrun pulse at stop end, 16-tick GAP, then tx_done.
REQ-033 Assert n_rst during the 4th data slot -> q=1 and busy=0 immediately; after release, push 0x81 -> a clean frame is sent.
REQ-034 clk_en high 1 clk in 3 -> each slot lasts 24 clks; the bit sequence is identical to REQ-029.
